// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: decoder opcode/funct constants, fetch FSM
// state encoding and default fetch-unit parameters.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    localparam logic [31:0] DEF_RESET_PC      = 32'h0000_3000;
    localparam logic [31:0] DEF_SYS_EXIT_CODE = 32'd10;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        HALT,
        FAULT
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface fetch_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection from decoder controls; flags a misaligned jr.
module next_pc_mux (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic [31:0] rs_data,
    input  logic        branch,
    input  logic        equ,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        alu_eq,
    output logic [31:0] target,
    output logic        misaligned
);

    logic        take_branch;
    logic [31:0] branch_offset;

    always_comb begin
        take_branch   = branch & (equ ? alu_eq : ~alu_eq);
        branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        target        = pc_plus4;
        if (jump_reg) begin
            target = rs_data;
        end else if (jump) begin
            target = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (take_branch) begin
            target = pc_plus4 + branch_offset;
        end
        misaligned = jump_reg & (rs_data[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing for the multi-cycle MIPS core:
// FETCH/EXEC/HALT/FAULT control, PC register, instruction latch, retire counter.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = DEF_RESET_PC,
    parameter logic [31:0] SYS_EXIT_CODE = DEF_SYS_EXIT_CODE
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               branch,
    input  logic               equ,
    input  logic               jump,
    input  logic               jump_reg,
    input  logic               jal,
    input  logic               sys,
    input  logic               alu_eq,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        v0_data,
    input  logic               stall,
    input  logic               go,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        retired
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  retired_q;
    logic         req_q;
    logic         valid_q;
    logic         halted_q;
    logic         fault_q;

    logic [31:0]  pc_plus4_d;
    logic [31:0]  pc_d;
    logic [31:0]  retired_d;
    logic         misaligned;
    logic         exit_req;

    assign pc_plus4_d = pc_q + 32'd4;
    assign retired_d  = retired_q + 32'd1;
    assign exit_req   = sys && (v0_data == SYS_EXIT_CODE);

    next_pc_mux u_next_pc_mux (
        .pc_plus4   (pc_plus4_d),
        .instr      (instr_q[25:0]),
        .rs_data    (rs_data),
        .branch     (branch),
        .equ        (equ),
        .jump       (jump | jal),
        .jump_reg   (jump_reg),
        .alu_eq     (alu_eq),
        .target     (pc_d),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            fault_q <= 1'b1;
                            state_q <= FAULT;
                        end else begin
                            pc_q      <= pc_d;
                            retired_q <= retired_d;
                            if (exit_req) begin
                                halted_q <= 1'b1;
                                state_q  <= HALT;
                            end else begin
                                req_q   <= 1'b1;
                                state_q <= FETCH;
                            end
                        end
                    end
                end
                HALT: begin
                    if (go) begin
                        halted_q <= 1'b0;
                        req_q    <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                FAULT: begin
                end
            endcase
        end
    end

    // req_q is preset during reset so the request appears the cycle rst drops;
    // gating with rst also withdraws an in-flight request immediately.
    assign imem.imem_req  = req_q & ~rst;
    assign imem.imem_addr = pc_q;

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_d;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign retired     = retired_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and PC sequencing unit for the multi-cycle MIPS core. It is the upstream end of the instruction decoder. It fetches 32-bit words from instruction memory over a req/ack handshake and presents each instruction, which carries op and funct, for one decode/execute cycle. It then consumes the decoder's control-flow outputs (branch, equ, jump, jump_reg, jal, sys) to compute and commit the next PC.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset
- SYS_EXIT_CODE, 32'd10, $v0 value that makes syscall halt
- clk  in  1  system clock; one clock domain, rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  word address of fetch (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instr  out  32  latched instruction; op = instr[31:26], funct = instr[5:0]
- instr_valid  out  1  high in EXEC; decoder outputs meaningful
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4 (link value for jal)
- branch, equ, jump, jump_reg, jal, sys  in  1 each  decoder controls
- alu_eq  in  1  rs == rt compare result
- rs_data  in  32  register rs value (jr target)
- v0_data  in  32  register $v0 value (syscall code)
- stall  in  1  hold EXEC (hazard/multi-cycle ALU)
- go  in  1  resume from HALT
- halted  out  1  core stopped by syscall exit
- fault  out  1  misaligned jr target; sticky until rst
- retired  out  32  committed-instruction counter

## Operation
- States: FETCH, EXEC, HALT, FAULT.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, instr<=imem_rdata and go to EXEC.
- EXEC: instr_valid=1.
  - If stall, hold all state.
  - Otherwise commit: pc<=next_pc, retired<=retired+1.
  - Then go to HALT if sys && v0_data==SYS_EXIT_CODE, else to FETCH.
- next_pc priority (highest first):
  - jump_reg → rs_data. If rs_data[1:0]≠0, go to FAULT with pc unchanged and no retire.
  - jump (covers jal) → {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch && (equ ? alu_eq : ~alu_eq) → pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Otherwise → pc_plus4.
- A syscall that is not an exit (other v0 values) commits like a normal instruction.
- HALT: halted=1 and pc already points past the syscall. go → FETCH. go while not in HALT is ignored.
- FAULT: fault=1 and no requests are issued. Only rst leaves this state.
- Arithmetic is modulo 2^32: pc wraps silently and retired wraps 0xFFFF_FFFF→0.

## Timing
- While rst is high: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, fault=0, retired=0.
  - The state register is set to FETCH, so on the first clock after rst falls, imem_req=1 and imem_addr=RESET_PC.
- imem_ack in the same cycle as req is legal. Minimum throughput is 2 cycles per instruction (FETCH+EXEC). Each memory wait cycle adds 1.
- imem_req and imem_addr are stable from assertion until the ack cycle inclusive.
- imem_ack outside FETCH is ignored.
- rst mid-fetch drops req the same cycle, and any later ack for the abandoned fetch is ignored.
- rst has priority over go, stall and ack.
- stall and a commit condition in the same cycle: stall wins, and nothing changes.
- pc and pc_plus4 are registered/derived outputs, stable through the entire EXEC cycle.

## Structure
- The shared package mips_pkg holds:
  - opcode/funct constants already used by the decoder;
  - the fetch state enum (FETCH/EXEC/HALT/FAULT);
  - default SYS_EXIT_CODE.
- One combinational sub-module, next_pc_mux: inputs pc_plus4, instr, rs_data, controls and alu_eq; outputs target and misaligned.
- The FSM, pc register, instr latch and counter remain in fetch_sequencer.

## Test plan
- Reset and straight-line code: release rst with 3 non-branch instructions and ack latency 0.
  - Required: imem_addr 0x3000, 0x3004, 0x3008 on consecutive FETCH cycles, 2 cycles apart.
  - Required: retired=3 after the third EXEC.
- Taken beq: pc=0x3010, instr imm=0xFFFF, branch=1, equ=1, alu_eq=1 → next fetch at 0x3010.
  - Same case with alu_eq=0 → next fetch at 0x3014.
- j/jal: pc=0x3020, instr[25:0]=0x0000C10 → next fetch at 0x0000_3040, and pc_plus4=0x3024 during EXEC.
- jr:
  - rs_data=0x3100 → next fetch at 0x3100.
  - rs_data=0x3102 → fault=1, imem_req stays 0, and retired is unchanged.
- syscall:
  - v0=10 → halted=1 and pc=addr+4.
  - go pulse → fetch resumes at addr+4.
  - v0=1 → normal commit with no halt.
- Stall, wait and reset:
  - ack delayed 3 cycles → req/addr held 4 cycles.
  - stall held 2 cycles in EXEC → pc and retired frozen.
  - rst mid-FETCH followed by a stale ack → restart at 0x3000 with instr=0.
